// File: rtl/activation_decompressor.sv
// activation_decompressor
//   Expands one run-length-compressed activation tile held in the activation RAM
//   into a dense, raster-ordered stream of 8-bit values over the tile's center
//   region (halo excluded). RAM word 0 holds the entry count; each entry carries
//   a zero-run length in the index field and a value in the low 8 value bits.
//   Trailing zeros are not stored, so the stream is padded with zeros up to the
//   full center size.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 level request to decode one tile
//   bitwidth, kernel_size tile geometry, sampled when a decode begins
//   iaram_address         RAM read address (data returns one cycle later)
//   iaram_value           RAM read data (length in word 0, value in entries)
//   iaram_indices_value   RAM index field (zero-run length)
//   out_valid/out_ready   dense element handshake
//   out_value             element value
//   out_row, out_column   absolute tile coordinates of the element
//   done                  tile complete, held until start drops
//   error                 sticky: entries described more than the center region
module activation_decompressor #(
    parameter int unsigned RAM_WIDTH   = 10,
    parameter int unsigned TILE_SIZE   = 256,
    parameter int unsigned INDEX_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [1:0]                  bitwidth,
    input  logic [2:0]                  kernel_size,
    output logic [RAM_WIDTH-2:0]        iaram_address,
    input  logic [24:0]                 iaram_value,
    input  logic [INDEX_WIDTH-1:0]      iaram_indices_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_value,
    output logic [$clog2(TILE_SIZE):0]  out_row,
    output logic [$clog2(TILE_SIZE):0]  out_column,
    output logic                        done,
    output logic                        error
);

    localparam int unsigned ADDR_W = RAM_WIDTH - 1;
    localparam int unsigned POS_W  = $clog2(TILE_SIZE) + 1;
    localparam int unsigned CNT_W  = 2 * POS_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_REQ,
        S_LEN_WAIT,
        S_FETCH,
        S_ENTRY_WAIT,
        S_ZEROS,
        S_VALUE,
        S_PAD,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [POS_W-1:0]       halo_q, halo_d;
    logic [POS_W-1:0]       lim_q, lim_d;
    logic [POS_W-1:0]       side_q, side_d;
    logic [CNT_W-1:0]       center_q, center_d;
    logic [CNT_W-1:0]       emitted_q, emitted_d;
    logic [RAM_WIDTH-1:0]   length_q, length_d;
    logic [RAM_WIDTH-1:0]   ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] zrun_q, zrun_d;
    logic [7:0]             val_q, val_d;
    logic [POS_W-1:0]       row_d, col_d;
    logic                   error_d;
    logic                   valid_d, done_d;
    logic [7:0]             value_d;
    logic [ADDR_W-1:0]      addr_d;

    logic [1:0]             cfg_shift;
    logic [POS_W-1:0]       cfg_tile;
    logic [POS_W-1:0]       cfg_halo;
    logic                   hs;
    logic                   at_end;
    logic                   unused_value_bits;

    // Entry words only use the low byte; the length word uses RAM_WIDTH bits.
    assign unused_value_bits = ^iaram_value[24:RAM_WIDTH];

    // Tile geometry from the live inputs, captured only when a decode starts.
    assign cfg_shift = (bitwidth == 2'd1) ? 2'd1 : ((bitwidth == 2'd2) ? 2'd3 : 2'd0);
    assign cfg_tile  = POS_W'(TILE_SIZE >> cfg_shift);
    assign cfg_halo  = POS_W'((kernel_size - 3'd1) >> 1);

    assign hs     = out_valid && out_ready;
    assign at_end = (emitted_q == center_q);

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            halo_q        <= '0;
            lim_q         <= '0;
            side_q        <= '0;
            center_q      <= '0;
            emitted_q     <= '0;
            length_q      <= '0;
            ptr_q         <= '0;
            zrun_q        <= '0;
            val_q         <= '0;
            out_row       <= '0;
            out_column    <= '0;
            error         <= 1'b0;
            out_valid     <= 1'b0;
            out_value     <= '0;
            done          <= 1'b0;
            iaram_address <= '0;
        end else begin
            state_q       <= state_d;
            halo_q        <= halo_d;
            lim_q         <= lim_d;
            side_q        <= side_d;
            center_q      <= center_d;
            emitted_q     <= emitted_d;
            length_q      <= length_d;
            ptr_q         <= ptr_d;
            zrun_q        <= zrun_d;
            val_q         <= val_d;
            out_row       <= row_d;
            out_column    <= col_d;
            error         <= error_d;
            out_valid     <= valid_d;
            out_value     <= value_d;
            done          <= done_d;
            iaram_address <= addr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (start) state_d = S_LEN_REQ;
            S_LEN_REQ:    state_d = S_LEN_WAIT;
            S_LEN_WAIT:   state_d = (iaram_value[RAM_WIDTH-1:0] == '0) ? S_PAD : S_FETCH;
            S_FETCH:      state_d = S_ENTRY_WAIT;
            S_ENTRY_WAIT: state_d = (iaram_indices_value != '0) ? S_ZEROS : S_VALUE;
            S_ZEROS: begin
                if (at_end)                                     state_d = S_DONE;
                else if (hs && zrun_q == INDEX_WIDTH'(1))       state_d = S_VALUE;
            end
            S_VALUE: begin
                if (at_end)  state_d = S_DONE;
                else if (hs) state_d = (ptr_q == length_q) ? S_PAD : S_FETCH;
            end
            S_PAD:        if (at_end) state_d = S_DONE;
            S_DONE:       if (!start) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Datapath updates and next values of the registered outputs.
    always_comb begin
        halo_d    = halo_q;
        lim_d     = lim_q;
        side_d    = side_q;
        center_d  = center_q;
        emitted_d = emitted_q;
        length_d  = length_q;
        ptr_d     = ptr_q;
        zrun_d    = zrun_q;
        val_d     = val_q;
        row_d     = out_row;
        col_d     = out_column;
        error_d   = error;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    halo_d  = cfg_halo;
                    lim_d   = cfg_tile - cfg_halo;
                    side_d  = cfg_tile - (cfg_halo << 1);
                    error_d = 1'b0;
                end
            end
            S_LEN_REQ: center_d = CNT_W'(side_q) * CNT_W'(side_q);
            S_LEN_WAIT: begin
                length_d  = iaram_value[RAM_WIDTH-1:0];
                ptr_d     = RAM_WIDTH'(1);
                row_d     = halo_q;
                col_d     = halo_q;
                emitted_d = '0;
            end
            S_ENTRY_WAIT: begin
                zrun_d = iaram_indices_value;
                val_d  = iaram_value[7:0];
            end
            S_ZEROS, S_VALUE, S_PAD: begin
                if (at_end) begin
                    // Reaching the end with an entry still pending is an overrun.
                    if (state_q != S_PAD) error_d = 1'b1;
                end else if (hs) begin
                    emitted_d = emitted_q + CNT_W'(1);
                    if (out_column + POS_W'(1) == lim_q) begin
                        col_d = halo_q;
                        row_d = out_row + POS_W'(1);
                    end else begin
                        col_d = out_column + POS_W'(1);
                    end
                    if (state_q == S_ZEROS) zrun_d = zrun_q - INDEX_WIDTH'(1);
                    if (state_q == S_VALUE) ptr_d = ptr_q + RAM_WIDTH'(1);
                end
            end
            default: ;
        endcase

        // Outputs are registered from next-state values so they line up with the state.
        valid_d = ((state_d == S_ZEROS) || (state_d == S_VALUE) || (state_d == S_PAD))
                  && (emitted_d != center_d);
        value_d = (state_d == S_VALUE) ? val_d : 8'd0;
        done_d  = (state_d == S_DONE);
        addr_d  = (state_d == S_FETCH) ? ADDR_W'(ptr_d) : '0;
    end

endmodule

// File: tb/tb_activation_decompressor.sv
// Testbench for activation_decompressor: a behavioural RAM holds each tile image,
// a reference expansion of the entry list fills the expected queue, and the
// observed dense stream is popped against it per scenario.
module tb_activation_decompressor;

    typedef struct packed {
        logic [7:0] v;
        logic [8:0] r;
        logic [8:0] c;
    } elem_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  bitwidth;
    logic [2:0]  kernel_size;
    logic [8:0]  iaram_address;
    logic [24:0] iaram_value;
    logic [3:0]  iaram_indices_value;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_value;
    logic [8:0]  out_row;
    logic [8:0]  out_column;
    logic        done;
    logic        error;

    bit [24:0] mem_val [0:511];
    bit [3:0]  mem_idx [0:511];

    elem_t exp_q[$];
    elem_t obs_q[$];
    int    ent_z[$];
    int    ent_v[$];
    bit    exp_err;
    int    total = 0;
    int    bad = 0;
    int    hold_bad = 0;

    always #5 clk = ~clk;

    activation_decompressor #(
        .RAM_WIDTH(10),
        .TILE_SIZE(256),
        .INDEX_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .bitwidth(bitwidth),
        .kernel_size(kernel_size),
        .iaram_address(iaram_address),
        .iaram_value(iaram_value),
        .iaram_indices_value(iaram_indices_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_value(out_value),
        .out_row(out_row),
        .out_column(out_column),
        .done(done),
        .error(error)
    );

    // One-cycle read latency RAM.
    always @(posedge clk) begin
        iaram_value         <= mem_val[iaram_address];
        iaram_indices_value <= mem_idx[iaram_address];
    end

    // Writes the entry list into RAM and expands it into the expected stream.
    task automatic build_tile(input int bw, input int k);
        int tile, halo, side, center, n, total_el;
        elem_t e;
        exp_q.delete();
        obs_q.delete();
        hold_bad = 0;
        tile   = 256 >> ((bw == 1) ? 1 : ((bw == 2) ? 3 : 0));
        halo   = (k - 1) / 2;
        side   = tile - 2 * halo;
        center = side * side;
        mem_val[0] = {15'($urandom), 10'(ent_z.size())};
        mem_idx[0] = 4'($urandom);
        n = 0;
        total_el = 0;
        foreach (ent_z[i]) begin
            mem_val[i + 1] = {17'($urandom), 8'(ent_v[i])};
            mem_idx[i + 1] = 4'(ent_z[i]);
            for (int j = 0; j <= ent_z[i]; j++) begin
                total_el++;
                if (n < center) begin
                    e.v = (j == ent_z[i]) ? 8'(ent_v[i]) : 8'd0;
                    e.r = 9'(halo + n / side);
                    e.c = 9'(halo + n % side);
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
        exp_err = (total_el > center);
        while (n < center) begin
            e.v = 8'd0;
            e.r = 9'(halo + n / side);
            e.c = 9'(halo + n % side);
            exp_q.push_back(e);
            n++;
        end
    endtask

    task automatic launch(input int bw, input int k);
        @(negedge clk);
        bitwidth    = 2'(bw);
        kernel_size = 3'(k);
        start       = 1'b1;
    endtask

    task automatic end_tile();
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Runs the DUT until done, recording accepted elements and stall-hold violations.
    task automatic collect(input bit rand_ready, input int budget, output bit timed_out);
        bit    stalled;
        elem_t held, now;
        stalled   = 1'b0;
        held      = '0;
        timed_out = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            now.v = out_value;
            now.r = out_row;
            now.c = out_column;
            if (stalled && (!out_valid || now !== held)) hold_bad++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) obs_q.push_back(now);
            stalled = out_valid && !out_ready;
            held    = now;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, out_value, out_row, out_column, done, error, iaram_address} !== '0) begin
            bad++;
            $display("FAIL reset_held: got valid=%b val=%0d row=%0d col=%0d done=%b err=%b addr=%0d want all 0",
                     out_valid, out_value, out_row, out_column, done, error, iaram_address);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, done, error, iaram_address} !== '0) begin
            bad++;
            $display("FAIL reset_idle: got valid=%b done=%b err=%b addr=%0d want all 0",
                     out_valid, done, error, iaram_address);
        end
    endtask

    task automatic test_empty();
        bit to;
        elem_t o, e;
        ent_z.delete();
        ent_v.delete();
        build_tile(2, 3);
        launch(2, 3);
        collect(1'b0, 2000, to);
        total++;
        if (to) begin bad++; $display("FAIL empty_done: done=%b want 1 within budget", done); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL empty_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL empty_elem: got v=%0d r=%0d c=%0d want v=%0d r=%0d c=%0d", o.v, o.r, o.c, e.v, e.r, e.c);
                break;
            end
        end
        total++;
        if (error !== exp_err) begin bad++; $display("FAIL empty_error: got %b want %b", error, exp_err); end
        repeat (3) @(negedge clk);
        total++;
        if (!(done === 1'b1 && out_valid === 1'b0)) begin
            bad++;
            $display("FAIL no_restart: got done=%b valid=%b want done=1 valid=0", done, out_valid);
        end
        end_tile();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_clear: got %b want 0", done); end
    endtask

    task automatic test_runs();
        bit to;
        elem_t o, e;
        ent_z = '{2, 0};
        ent_v = '{5, 7};
        build_tile(2, 1);
        launch(2, 1);
        collect(1'b0, 3000, to);
        total++;
        if (to) begin bad++; $display("FAIL runs_done: done=%b want 1 within budget", done); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL runs_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL runs_elem: got v=%0d r=%0d c=%0d want v=%0d r=%0d c=%0d", o.v, o.r, o.c, e.v, e.r, e.c);
                break;
            end
        end
        total++;
        if (error !== exp_err) begin bad++; $display("FAIL runs_error: got %b want %b", error, exp_err); end
        end_tile();
    endtask

    task automatic test_max_run();
        bit to;
        elem_t o, e;
        ent_z = '{15, 0};
        ent_v = '{0, 9};
        build_tile(1, 5);
        launch(1, 5);
        collect(1'b0, 20000, to);
        total++;
        if (to) begin bad++; $display("FAIL maxrun_done: done=%b want 1 within budget", done); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL maxrun_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL maxrun_elem: got v=%0d r=%0d c=%0d want v=%0d r=%0d c=%0d", o.v, o.r, o.c, e.v, e.r, e.c);
                break;
            end
        end
        total++;
        if (error !== exp_err) begin bad++; $display("FAIL maxrun_error: got %b want %b", error, exp_err); end
        end_tile();
    endtask

    task automatic test_overrun();
        bit to;
        elem_t o, e;
        ent_z.delete();
        ent_v.delete();
        for (int i = 0; i < 43; i++) begin
            ent_z.push_back(15);
            ent_v.push_back(int'($urandom_range(1, 255)));
        end
        build_tile(2, 7);
        launch(2, 7);
        collect(1'b0, 2000, to);
        total++;
        if (to) begin bad++; $display("FAIL overrun_done: done=%b want 1 within budget", done); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL overrun_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL overrun_elem: got v=%0d r=%0d c=%0d want v=%0d r=%0d c=%0d", o.v, o.r, o.c, e.v, e.r, e.c);
                break;
            end
        end
        total++;
        if (error !== exp_err) begin bad++; $display("FAIL overrun_error: got %b want %b", error, exp_err); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL overrun_valid: got %b want 0", out_valid); end
        end_tile();
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL error_sticky: got %b want 1", error); end
    endtask

    task automatic test_stall();
        bit to;
        elem_t o, e;
        ent_z = '{2, 0};
        ent_v = '{5, 7};
        build_tile(2, 1);
        launch(2, 1);
        collect(1'b1, 8000, to);
        total++;
        if (to) begin bad++; $display("FAIL stall_done: done=%b want 1 within budget", done); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_elem: got v=%0d r=%0d c=%0d want v=%0d r=%0d c=%0d", o.v, o.r, o.c, e.v, e.r, e.c);
                break;
            end
        end
        total++;
        if (hold_bad != 0) begin bad++; $display("FAIL stall_hold: got %0d changes while stalled want 0", hold_bad); end
        total++;
        if (error !== exp_err) begin bad++; $display("FAIL stall_error: got %b want %b", error, exp_err); end
        end_tile();
    endtask

    task automatic test_reset_mid();
        bit to, seen;
        elem_t o, e;
        ent_z = '{2, 0};
        ent_v = '{5, 7};
        build_tile(2, 1);
        launch(2, 1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        total++;
        if (!(seen && out_value === 8'd0)) begin
            bad++;
            $display("FAIL midreset_zeros: got valid=%b val=%0d want valid=1 val=0", out_valid, out_value);
        end
        reset_n = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, out_value, out_row, out_column, done, error, iaram_address} !== '0) begin
            bad++;
            $display("FAIL midreset_clear: got valid=%b val=%0d row=%0d col=%0d done=%b err=%b addr=%0d want all 0",
                     out_valid, out_value, out_row, out_column, done, error, iaram_address);
        end
        reset_n = 1'b1;
        @(negedge clk);
        build_tile(2, 1);
        launch(2, 1);
        collect(1'b0, 3000, to);
        total++;
        if (to) begin bad++; $display("FAIL restart_done: done=%b want 1 within budget", done); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL restart_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL restart_elem: got v=%0d r=%0d c=%0d want v=%0d r=%0d c=%0d", o.v, o.r, o.c, e.v, e.r, e.c);
                break;
            end
        end
        end_tile();
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        bitwidth    = 2'd0;
        kernel_size = 3'd1;
        out_ready   = 1'b1;
        test_reset();
        test_empty();
        test_runs();
        test_max_run();
        test_overrun();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
